ahb_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single AHB-Lite master command port among NUM_REQ requesters. It latches the winning requester's command and pulses `start` to the master. It then tracks address and data phases on the bus using HTRANS, HREADY and HRSP, and returns completion, error and read data to the granted requester. A watchdog aborts transfers that do not finish in time.

---
 rtl/ahb_req_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_req_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite master command port and returns done/err/read data to the winner.
// Latency: start one cycle after req is sampled in IDLE, done one cycle after the last beat; HREADY low stalls counting, and a watchdog aborts slow transfers.
module ahb_req_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*3-1:0]             req_size,
    input  logic [NUM_REQ*3-1:0]             req_burst,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic                             err,
    output logic                             timeout,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rd_valid,
    output logic                             start,
    output logic [ADDR_WIDTH-1:0]            addr_ip,
    output logic [2:0]                       hsize_ip,
    output logic [DATA_WIDTH-1:0]            data_ip,
    output logic [2:0]                       hburst_ip,
    output logic                             hwrite_ip,
    input  logic [1:0]                       HTRANS,
    input  logic                             HREADY,
    input  logic                             HRSP,
    input  logic [DATA_WIDTH-1:0]            HRDATA
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t               state, state_nxt;
    cmd_t                 cmd_q, win_cmd;
    logic [IDX_W-1:0]     rr_ptr, gnt_idx, win_idx, cand;
    logic                 win_found;
    logic [4:0]           addr_left, data_left;
    logic [WD_W-1:0]      wdog;
    logic                 pend, err_q, to_q;
    logic                 in_xfer, acc, beat, last_beat, wd_exp, timed_out;
    logic                 unused_htrans;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign unused_htrans = HTRANS[0];

    function automatic logic [4:0] burst_beats(input logic [2:0] b);
        case (b[2:1])
            2'b00:   return 5'd1;
            2'b01:   return 5'd4;
            2'b10:   return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_cmd       = '0;
        win_cmd.addr  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        win_cmd.size  = req_size[int'(win_idx)*3 +: 3];
        win_cmd.burst = req_burst[int'(win_idx)*3 +: 3];
        win_cmd.write = req_write[win_idx];
        win_cmd.wdata = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_xfer   = (state == S_ADDR) || (state == S_DATA);
    assign acc       = (state == S_ADDR) && HTRANS[1] && HREADY;
    assign beat      = in_xfer && pend && HREADY;
    assign last_beat = beat && (data_left == 5'd1);
    assign wd_exp    = in_xfer && (wdog == WD_W'(TIMEOUT - 1));
    // A final beat landing on the watchdog edge counts as a normal completion.
    assign timed_out = wd_exp && !last_beat;

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_ADDR;
            S_ADDR: begin
                if (wd_exp)
                    state_nxt = S_DONE;
                else if (acc && (addr_left == 5'd1))
                    state_nxt = S_DATA;
            end
            S_DATA:  if (last_beat || wd_exp) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            cmd_q     <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            addr_left <= '0;
            data_left <= '0;
            wdog      <= '0;
            pend      <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            start     <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            timeout   <= 1'b0;
            rd_valid  <= 1'b0;
            rdata     <= '0;
        end else begin
            start    <= 1'b0;
            done     <= '0;
            err      <= 1'b0;
            timeout  <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cmd_q     <= win_cmd;
                        gnt       <= NUM_REQ'(1) << win_idx;
                        gnt_idx   <= win_idx;
                        addr_left <= burst_beats(win_cmd.burst);
                        data_left <= burst_beats(win_cmd.burst);
                        start     <= 1'b1;
                        wdog      <= '0;
                        pend      <= 1'b0;
                        err_q     <= 1'b0;
                        to_q      <= 1'b0;
                    end
                end
                S_ADDR, S_DATA: begin
                    wdog <= wdog + WD_W'(1);
                    if (acc)
                        addr_left <= addr_left - 5'd1;
                    // A stalled data phase stays pending until HREADY returns.
                    if (HREADY)
                        pend <= acc;
                    if (beat) begin
                        data_left <= data_left - 5'd1;
                        if (!cmd_q.write) begin
                            rdata    <= HRDATA;
                            rd_valid <= 1'b1;
                        end
                        if (HRSP)
                            err_q <= 1'b1;
                    end
                    if (timed_out) begin
                        to_q  <= 1'b1;
                        err_q <= 1'b1;
                    end
                    if (state_nxt == S_DONE) begin
                        done    <= gnt;
                        err     <= err_q | (beat & HRSP) | timed_out;
                        timeout <= to_q | timed_out;
                    end
                end
                S_DONE: begin
                    gnt    <= '0;
                    rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
                    err_q  <= 1'b0;
                    to_q   <= 1'b0;
                    pend   <= 1'b0;
                    wdog   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign addr_ip   = cmd_q.addr;
    assign hsize_ip  = cmd_q.size;
    assign hburst_ip = cmd_q.burst;
    assign hwrite_ip = cmd_q.write;
    assign data_ip   = cmd_q.wdata;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: the bench plays the AHB master and requesters.
// Expected values are hand-derived from the cycle timing of each directed step.
module tb_ahb_req_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 256;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*3-1:0]  req_size;
    logic [NR*3-1:0]  req_burst;
    logic [NR-1:0]    req_write;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic             err;
    logic             timeout;
    logic [DW-1:0]    rdata;
    logic             rd_valid;
    logic             start;
    logic [AW-1:0]    addr_ip;
    logic [2:0]       hsize_ip;
    logic [DW-1:0]    data_ip;
    logic [2:0]       hburst_ip;
    logic             hwrite_ip;
    logic [1:0]       HTRANS;
    logic             HREADY;
    logic             HRSP;
    logic [DW-1:0]    HRDATA;

    int vectors     = 0;
    int miscompares = 0;

    // Stalled INCR4 read: HREADY low for two cycles between beats 1 and 2.
    int st_trans [7] = '{2, 3, 3, 3, 3, 3, 0};
    int st_rdy   [7] = '{1, 1, 0, 0, 1, 1, 1};
    int st_data  [7] = '{0, 1, 'hBAD, 'hBAD, 2, 3, 4};
    int st_vld   [7] = '{0, 1, 0, 0, 1, 1, 1};
    logic [3:0] rr_exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    ahb_req_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req(req), .req_addr(req_addr),
        .req_size(req_size), .req_burst(req_burst), .req_write(req_write),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
        .timeout(timeout), .rdata(rdata), .rd_valid(rd_valid), .start(start),
        .addr_ip(addr_ip), .hsize_ip(hsize_ip), .data_ip(data_ip),
        .hburst_ip(hburst_ip), .hwrite_ip(hwrite_ip), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRSP(HRSP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int k, input logic [AW-1:0] a, input logic [2:0] s,
                           input logic [2:0] b, input logic w, input logic [DW-1:0] d);
        req_addr[k*AW +: AW]  = a;
        req_size[k*3 +: 3]    = s;
        req_burst[k*3 +: 3]   = b;
        req_write[k]          = w;
        req_wdata[k*DW +: DW] = d;
    endtask

    // Starts and ends in an IDLE cycle; one NONSEQ the cycle after start.
    task automatic single_xfer(input logic [3:0] exp_g, input string tag);
        tick();
        chk({tag, "_gnt"}, gnt, exp_g);
        chk({tag, "_start"}, start, 1'b1);
        tick();
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        tick();
        chk({tag, "_done"}, done, exp_g);
        chk({tag, "_err"}, err, 1'b0);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, gnt, '0);
        chk({tag, "_done"}, done, '0);
        chk({tag, "_flags"}, {err, timeout, rd_valid, start, hwrite_ip}, 5'b0);
        chk({tag, "_rdata"}, rdata, '0);
        chk({tag, "_addr"}, addr_ip, '0);
        chk({tag, "_data"}, data_ip, '0);
        chk({tag, "_sizeburst"}, {hsize_ip, hburst_ip}, 6'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        HRESET = 1'b0; req = '0; req_addr = '0; req_size = '0; req_burst = '0;
        req_write = '0; req_wdata = '0; HTRANS = 2'b00; HREADY = 1'b1; HRSP = 1'b0; HRDATA = '0;
        tick(); tick(); tick();
        chk_reset_outputs("reset");
        HRESET = 1'b1;

        // Single write from requester 1.
        set_cmd(1, 20'h00ABC, 3'b010, 3'b000, 1'b1, 32'hDEADBEEF);
        req = 4'b0010;
        tick();
        chk("wr_gnt", gnt, 4'b0010);
        chk("wr_start", start, 1'b1);
        chk("wr_addr", addr_ip, 20'h00ABC);
        chk("wr_data", data_ip, 32'hDEADBEEF);
        chk("wr_dir_size", {hwrite_ip, hsize_ip}, 4'b1010);
        tick();
        chk("wr_start_pulse", start, 1'b0);
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        chk("wr_done_early", done, 4'b0000);
        tick();
        chk("wr_done", done, 4'b0010);
        chk("wr_err_to", {err, timeout, rd_valid}, 3'b000);
        chk("wr_hold", {gnt, addr_ip}, {4'b0010, 20'h00ABC});
        req = 4'b0000;
        tick();
        chk("wr_idle", {done, gnt, start}, 9'b0);

        // INCR4 read from requester 2, no stalls.
        set_cmd(2, 20'h01000, 3'b010, 3'b011, 1'b0, 32'h0);
        req = 4'b0100;
        tick();
        chk("r4_gnt", gnt, 4'b0100);
        chk("r4_burst", hburst_ip, 3'b011);
        tick();
        for (int i = 0; i < 5; i++) begin
            HTRANS = (i == 0) ? 2'b10 : ((i < 4) ? 2'b11 : 2'b00);
            HRDATA = 32'(i);
            tick();
            chk("r4_rdvld", rd_valid, (i >= 1));
            if (i >= 1) chk("r4_rdata", rdata, 32'(i));
            chk("r4_done", done, (i == 4) ? 4'b0100 : 4'b0000);
        end
        req = 4'b0000;
        tick();

        // INCR4 read from requester 3 with a two-cycle stall.
        set_cmd(3, 20'h02000, 3'b010, 3'b011, 1'b0, 32'h0);
        req = 4'b1000;
        tick();
        chk("st_gnt", gnt, 4'b1000);
        tick();
        for (int i = 0; i < 7; i++) begin
            HTRANS = st_trans[i][1:0];
            HREADY = st_rdy[i][0];
            HRDATA = 32'(st_data[i]);
            tick();
            chk("st_rdvld", rd_valid, st_vld[i][0]);
            if (st_vld[i] != 0) chk("st_rdata", rdata, 32'(st_data[i]));
            chk("st_done", done, (i == 6) ? 4'b1000 : 4'b0000);
        end
        req = 4'b0000;
        tick();

        // Round robin with all singles.
        for (int k = 0; k < NR; k++) set_cmd(k, 20'(k * 16), 3'b010, 3'b000, 1'b0, 32'h0);
        req = 4'b1111;
        for (int i = 0; i < 7; i++) single_xfer(rr_exp[i], "rr");
        req = 4'b0101;
        single_xfer(4'b0001, "rr_wrap");
        req = 4'b0000;

        // Error response on beat 2 of an INCR4 read from requester 1.
        set_cmd(1, 20'h03000, 3'b010, 3'b011, 1'b0, 32'h0);
        req = 4'b0010;
        tick();
        chk("er_gnt", gnt, 4'b0010);
        tick();
        for (int i = 0; i < 5; i++) begin
            HTRANS = (i == 0) ? 2'b10 : ((i < 4) ? 2'b11 : 2'b00);
            HRDATA = 32'(i + 16);
            HRSP   = (i == 2);
            tick();
            chk("er_rdvld", rd_valid, (i >= 1));
            chk("er_done", done, (i == 4) ? 4'b0010 : 4'b0000);
        end
        HRSP = 1'b0;
        chk("er_err_to", {err, timeout}, 2'b10);
        req = 4'b0000;
        tick();
        req = 4'b0100;
        single_xfer(4'b0100, "er_next");
        req = 4'b0000;

        // Watchdog: HREADY stuck low on a single write from requester 3.
        set_cmd(3, 20'h04000, 3'b000, 3'b000, 1'b1, 32'h12345678);
        req = 4'b1000;
        tick();
        chk("to_gnt", gnt, 4'b1000);
        HREADY = 1'b0;
        HTRANS = 2'b10;
        tick();
        n = 0;
        for (int k = 1; k <= TO + 100; k++) begin
            tick();
            if (done != 0) begin
                n = k;
                break;
            end
        end
        chk("to_cycles", n, TO);
        chk("to_done", done, 4'b1000);
        chk("to_err_to", {err, timeout}, 2'b11);
        req = 4'b0000; HREADY = 1'b1; HTRANS = 2'b00;
        tick();

        // Reset while in DATA of an INCR8 read from requester 0.
        set_cmd(0, 20'h05000, 3'b010, 3'b101, 1'b0, 32'hCAFEF00D);
        req = 4'b0001;
        tick();
        chk("rs_gnt", gnt, 4'b0001);
        tick();
        for (int i = 0; i < 8; i++) begin
            HTRANS = (i == 0) ? 2'b10 : 2'b11;
            HRDATA = 32'hA5A50000 + 32'(i);
            tick();
        end
        HTRANS = 2'b00;
        chk("rs_pre_rdvld", rd_valid, 1'b1);
        HRESET = 1'b0;
        tick();
        chk_reset_outputs("rs_post");
        tick();
        chk("rs_no_done", done, 4'b0000);
        HRESET = 1'b1;
        set_cmd(0, 20'h06000, 3'b010, 3'b000, 1'b0, 32'h0);
        single_xfer(4'b0001, "rs_fresh");
        req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
